// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the ID-stage ALU decoder:
//   - ALU_* : ALUControl codes consumed by the EX-stage ALU (0..29)
//   - OP_*  : MIPS primary opcodes (instr[31:26])
//   - FN_*  : R-type / SPECIAL2 function codes (instr[5:0])
//   - RT_*  : REGIMM rt selectors (instr[20:16]) for bgez/bltz
// ----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALUControl codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDI = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_MUL  = 5'd3;
    localparam logic [4:0] ALU_LW   = 5'd4;
    localparam logic [4:0] ALU_SW   = 5'd5;
    localparam logic [4:0] ALU_SB   = 5'd6;
    localparam logic [4:0] ALU_LH   = 5'd7;
    localparam logic [4:0] ALU_LB   = 5'd8;
    localparam logic [4:0] ALU_SH   = 5'd9;
    localparam logic [4:0] ALU_BGEZ = 5'd10;
    localparam logic [4:0] ALU_BEQ  = 5'd11;
    localparam logic [4:0] ALU_BNE  = 5'd12;
    localparam logic [4:0] ALU_BGTZ = 5'd13;
    localparam logic [4:0] ALU_BLEZ = 5'd14;
    localparam logic [4:0] ALU_BLTZ = 5'd15;
    localparam logic [4:0] ALU_J    = 5'd16;
    localparam logic [4:0] ALU_JR   = 5'd17;
    localparam logic [4:0] ALU_JAL  = 5'd18;
    localparam logic [4:0] ALU_AND  = 5'd19;
    localparam logic [4:0] ALU_ANDI = 5'd20;
    localparam logic [4:0] ALU_OR   = 5'd21;
    localparam logic [4:0] ALU_NOR  = 5'd22;
    localparam logic [4:0] ALU_XOR  = 5'd23;
    localparam logic [4:0] ALU_ORI  = 5'd24;
    localparam logic [4:0] ALU_XORI = 5'd25;
    localparam logic [4:0] ALU_SLL  = 5'd26;
    localparam logic [4:0] ALU_SRL  = 5'd27;
    localparam logic [4:0] ALU_SLT  = 5'd28;
    localparam logic [4:0] ALU_SLTI = 5'd29;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // Function codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b000010;   // under OP_SPECIAL2

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

endpackage

// File: rtl/alu_ctrl_lut.sv
// ----------------------------------------------------------------------------
// alu_ctrl_lut
// Purely combinational decode of a MIPS instruction word into the ALUControl
// code and operand-select flags. Unknown encodings yield code 0, all flags 0,
// and illegal=1.
// Ports:
//   instr      in   32      instruction word
//   alu_ctrl   out  CTRL_W  ALUControl code
//   alu_src    out  1       B operand = immediate
//   shamt_sel  out  1       B operand = instr[10:6]
//   zero_ext   out  1       immediate is zero-extended
//   illegal    out  1       encoding not recognised
// ----------------------------------------------------------------------------
module alu_ctrl_lut
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5
) (
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_src,
    output logic              shamt_sel,
    output logic              zero_ext,
    output logic              illegal
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] code;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rt = instr[20:16];

    assign alu_ctrl = CTRL_W'(code);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        code      = ALU_ADD;
        alu_src   = 1'b0;
        shamt_sel = 1'b0;
        zero_ext  = 1'b0;
        illegal   = 1'b0;

        unique case (op)
            OP_RTYPE: begin
                unique case (fn)
                    FN_ADD: code = ALU_ADD;
                    FN_SUB: code = ALU_SUB;
                    FN_AND: code = ALU_AND;
                    FN_OR:  code = ALU_OR;
                    FN_NOR: code = ALU_NOR;
                    FN_XOR: code = ALU_XOR;
                    FN_SLT: code = ALU_SLT;
                    FN_JR:  code = ALU_JR;
                    FN_SLL: begin code = ALU_SLL; shamt_sel = 1'b1; end
                    FN_SRL: begin code = ALU_SRL; shamt_sel = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                if (fn == FN_MUL) code = ALU_MUL;
                else              illegal = 1'b1;
            end
            OP_ADDI: begin code = ALU_ADDI; alu_src = 1'b1; end
            OP_SLTI: begin code = ALU_SLTI; alu_src = 1'b1; end
            OP_ANDI: begin code = ALU_ANDI; alu_src = 1'b1; zero_ext = 1'b1; end
            OP_ORI:  begin code = ALU_ORI;  alu_src = 1'b1; zero_ext = 1'b1; end
            OP_XORI: begin code = ALU_XORI; alu_src = 1'b1; zero_ext = 1'b1; end
            OP_LW:   begin code = ALU_LW;   alu_src = 1'b1; end
            OP_SW:   begin code = ALU_SW;   alu_src = 1'b1; end
            OP_SB:   begin code = ALU_SB;   alu_src = 1'b1; end
            OP_LH:   begin code = ALU_LH;   alu_src = 1'b1; end
            OP_LB:   begin code = ALU_LB;   alu_src = 1'b1; end
            OP_SH:   begin code = ALU_SH;   alu_src = 1'b1; end
            OP_BEQ:  code = ALU_BEQ;
            OP_BNE:  code = ALU_BNE;
            OP_BLEZ: code = ALU_BLEZ;
            OP_BGTZ: code = ALU_BGTZ;
            OP_REGIMM: begin
                if      (rt == RT_BGEZ) code = ALU_BGEZ;
                else if (rt == RT_BLTZ) code = ALU_BLTZ;
                else                    illegal = 1'b1;
            end
            OP_J:    code = ALU_J;
            OP_JAL:  code = ALU_JAL;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_decoder.sv
// ----------------------------------------------------------------------------
// id_ex_alu_decoder
// ID-stage ALU decoder plus the ID/EX pipeline register for its outputs.
// Per edge: flush (bubble) beats stall (hold) beats load. A load with
// id_valid=0 also produces a bubble.
// Optional feature macro: ILLEGAL_CNT_EN -- saturating counter of illegal
// instructions loaded into ID/EX. Without it illegal_cnt is tied to 0.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   id_valid       id_instr is a real instruction
//   id_instr       instruction from IF/ID
//   stall          hold ID/EX
//   flush          load a bubble into ID/EX
//   ex_valid       ID/EX holds a real instruction
//   ex_alu_ctrl    ALUControl code
//   ex_alu_src     B operand = immediate
//   ex_shamt_sel   B operand = shamt
//   ex_zero_ext    zero-extend immediate
//   ex_illegal     ID/EX holds an undecodable instruction
//   illegal_cnt    saturating illegal-instruction count
// ----------------------------------------------------------------------------
module id_ex_alu_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic              ex_alu_src,
    output logic              ex_shamt_sel,
    output logic              ex_zero_ext,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [CTRL_W-1:0] dec_alu_ctrl;
    logic              dec_alu_src;
    logic              dec_shamt_sel;
    logic              dec_zero_ext;
    logic              dec_illegal;
    logic              load_en;

    alu_ctrl_lut #(.CTRL_W(CTRL_W)) u_lut (
        .instr     (id_instr),
        .alu_ctrl  (dec_alu_ctrl),
        .alu_src   (dec_alu_src),
        .shamt_sel (dec_shamt_sel),
        .zero_ext  (dec_zero_ext),
        .illegal   (dec_illegal)
    );

    // A normal load edge: neither flushed nor held.
    assign load_en = !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_alu_ctrl  <= '0;
            ex_alu_src   <= 1'b0;
            ex_shamt_sel <= 1'b0;
            ex_zero_ext  <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_alu_ctrl  <= '0;
            ex_alu_src   <= 1'b0;
            ex_shamt_sel <= 1'b0;
            ex_zero_ext  <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_alu_ctrl  <= dec_alu_ctrl;
                ex_alu_src   <= dec_alu_src;
                ex_shamt_sel <= dec_shamt_sel;
                ex_zero_ext  <= dec_zero_ext;
                ex_illegal   <= dec_illegal;
            end else begin
                ex_alu_ctrl  <= '0;
                ex_alu_src   <= 1'b0;
                ex_shamt_sel <= 1'b0;
                ex_zero_ext  <= 1'b0;
                ex_illegal   <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_en && id_valid && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = '0;
    logic unused_load_en;
    assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_id_ex_alu_decoder.sv
// ----------------------------------------------------------------------------
// tb_id_ex_alu_decoder
// Directed-vector bench for id_ex_alu_decoder. Inputs change 1ns after the
// rising edge; outputs are sampled at the same point, away from the edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_alu_decoder;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_alu_ctrl;
    logic        ex_alu_src;
    logic        ex_shamt_sel;
    logic        ex_zero_ext;
    logic        ex_illegal;
    logic [7:0]  illegal_cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_alu_decoder #(.CTRL_W(5), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_alu_src   (ex_alu_src),
        .ex_shamt_sel (ex_shamt_sel),
        .ex_zero_ext  (ex_zero_ext),
        .ex_illegal   (ex_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  ctrl;
        logic        src;
        logic        shamt;
        logic        zext;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {valid, illegal, zero_ext, shamt_sel, alu_src, alu_ctrl}
    function automatic logic [31:0] obs();
        return {22'd0, ex_valid, ex_illegal, ex_zero_ext, ex_shamt_sel, ex_alu_src, ex_alu_ctrl};
    endfunction

    function automatic logic [31:0] pack(input logic v, input logic ill, input logic zx,
                                         input logic sh, input logic src, input logic [4:0] c);
        return {22'd0, v, ill, zx, sh, src, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input logic [31:0] i, input logic [4:0] c,
                           input logic s, input logic sh, input logic z, input logic il);
        vec_t v;
        v.name = n; v.instr = i; v.ctrl = c; v.src = s; v.shamt = sh; v.zext = z; v.ill = il;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; stall = 1'b0; flush = 1'b0;

        add_vec("add",   32'h0232_4020, 5'd0,  0, 0, 0, 0);
        add_vec("sub",   32'h0000_0022, 5'd2,  0, 0, 0, 0);
        add_vec("and",   32'h0000_0024, 5'd19, 0, 0, 0, 0);
        add_vec("or",    32'h0000_0025, 5'd21, 0, 0, 0, 0);
        add_vec("nor",   32'h0000_0027, 5'd22, 0, 0, 0, 0);
        add_vec("xor",   32'h0000_0026, 5'd23, 0, 0, 0, 0);
        add_vec("slt",   32'h0000_002A, 5'd28, 0, 0, 0, 0);
        add_vec("jr",    32'h0000_0008, 5'd17, 0, 0, 0, 0);
        add_vec("sll",   32'h0001_1080, 5'd26, 0, 1, 0, 0);
        add_vec("srl",   32'h0001_1082, 5'd27, 0, 1, 0, 0);
        add_vec("mul",   32'h7000_0002, 5'd3,  0, 0, 0, 0);
        add_vec("addi",  32'h2000_0005, 5'd1,  1, 0, 0, 0);
        add_vec("slti",  32'h2800_0005, 5'd29, 1, 0, 0, 0);
        add_vec("andi",  32'h3000_00FF, 5'd20, 1, 0, 1, 0);
        add_vec("ori",   32'h3508_FFFF, 5'd24, 1, 0, 1, 0);
        add_vec("xori",  32'h3800_0001, 5'd25, 1, 0, 1, 0);
        add_vec("lw",    32'h8D09_0004, 5'd4,  1, 0, 0, 0);
        add_vec("sw",    32'hAC00_0000, 5'd5,  1, 0, 0, 0);
        add_vec("sb",    32'hA000_0000, 5'd6,  1, 0, 0, 0);
        add_vec("lh",    32'h8400_0000, 5'd7,  1, 0, 0, 0);
        add_vec("lb",    32'h8000_0000, 5'd8,  1, 0, 0, 0);
        add_vec("sh",    32'hA400_0000, 5'd9,  1, 0, 0, 0);
        add_vec("beq",   32'h1000_0000, 5'd11, 0, 0, 0, 0);
        add_vec("bne",   32'h1400_0000, 5'd12, 0, 0, 0, 0);
        add_vec("blez",  32'h1800_0000, 5'd14, 0, 0, 0, 0);
        add_vec("bgtz",  32'h1C00_0000, 5'd13, 0, 0, 0, 0);
        add_vec("bgez",  32'h0401_0000, 5'd10, 0, 0, 0, 0);
        add_vec("bltz",  32'h0400_0000, 5'd15, 0, 0, 0, 0);
        add_vec("j",     32'h0800_0000, 5'd16, 0, 0, 0, 0);
        add_vec("jal",   32'h0C00_0000, 5'd18, 0, 0, 0, 0);
        add_vec("nop",   32'h0000_0000, 5'd26, 0, 1, 0, 0);
        add_vec("ill_op",   32'hFC00_0000, 5'd0, 0, 0, 0, 1);
        add_vec("ill_fn",   32'h0000_003F, 5'd0, 0, 0, 0, 1);
        add_vec("ill_sp2",  32'h7000_0000, 5'd0, 0, 0, 0, 1);
        add_vec("ill_rt",   32'h0402_0000, 5'd0, 0, 0, 0, 1);

        // Reset state
        #12;
        check("reset_state", obs(), 32'd0);
        check("reset_cnt", {24'd0, illegal_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Decode sweep: one cycle latency
        foreach (vecs[i]) begin
            id_valid = 1'b1;
            id_instr = vecs[i].instr;
            tick();
            check({"dec_", vecs[i].name}, obs(),
                  pack(1'b1, vecs[i].ill, vecs[i].zext, vecs[i].shamt, vecs[i].src, vecs[i].ctrl));
        end

        // Stall hold then release
        id_instr = 32'h0000_0022;                 // sub
        tick();
        check("stall_load_sub", {27'd0, ex_alu_ctrl}, 32'd2);
        id_instr = 32'h0000_0024;                 // and
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_hold_%0d", k), obs(), pack(1, 0, 0, 0, 0, 5'd2));
        end
        stall = 1'b0;
        tick();
        check("stall_release", {27'd0, ex_alu_ctrl}, 32'd19);

        // Flush beats simultaneous stall
        flush = 1'b1; stall = 1'b1;
        tick();
        check("flush_stall", obs(), 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Bubble: id_valid=0 with a decodable word
        id_instr = 32'h3508_FFFF;
        id_valid = 1'b0;
        tick();
        check("bubble", obs(), 32'd0);

        // Stall keeps a bubble as a bubble
        id_valid = 1'b1;
        stall = 1'b1;
        tick();
        check("stall_bubble", obs(), 32'd0);
        stall = 1'b0;

        // NOP with id_valid=1
        id_instr = 32'h0000_0000;
        tick();
        check("nop_legal", obs(), pack(1, 0, 0, 1, 0, 5'd26));

        // Async reset mid-cycle while ex_valid=1
        id_instr = 32'h8D09_0004;
        tick();
        check("pre_reset_valid", obs(), pack(1, 0, 0, 0, 1, 5'd4));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", obs(), 32'd0);
        #1 rst_n = 1'b1;
        tick();

`ifdef ILLEGAL_CNT_EN
        // Counter: 3 illegal loads, a flushed and a stalled illegal, then saturate
        id_valid = 1'b1;
        id_instr = 32'hFC00_0000;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("cnt_three", {24'd0, illegal_cnt}, 32'd3);
        flush = 1'b1;
        tick();
        check("cnt_flush_nocount", {24'd0, illegal_cnt}, 32'd3);
        flush = 1'b0; stall = 1'b1;
        tick();
        check("cnt_stall_nocount", {24'd0, illegal_cnt}, 32'd3);
        stall = 1'b0;
        id_valid = 1'b0;
        tick();
        check("cnt_bubble_nocount", {24'd0, illegal_cnt}, 32'd3);
        id_valid = 1'b1;
        for (int k = 0; k < 297; k++) tick();
        check("cnt_saturate", {24'd0, illegal_cnt}, 32'd255);
        check("cnt_ex_illegal", obs(), pack(1, 1, 0, 0, 0, 5'd0));
`else
        // Counter absent: port must stay 0 after illegal loads
        id_valid = 1'b1;
        id_instr = 32'hFC00_0000;
        for (int k = 0; k < 4; k++) tick();
        check("cnt_tied_ex_illegal", obs(), pack(1, 1, 0, 0, 0, 5'd0));
        check("cnt_tied_zero", {24'd0, illegal_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
